bbox_sample_iter: RTL and testbench

// - Rasterizer test-iterator stage; sits directly upstream of sampletest.
// - Accepts one triangle plus its sample-grid-snapped bounding box from the bbox stage.
// - Walks every sample position in the box in raster order, one per cycle.
// - Presents triangle, colour and sample location to sampletest with a ready/valid handshake toward bbox.

---
 rtl/bbox_sample_iter.sv | 168 ++++++++++++++++
 tb/tb_bbox_sample_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bbox_sample_iter.sv
// Rasterizer test iterator: walks the sample grid of a triangle's bounding box in raster order.
// Optional macro EMPTY_BOX_SKIP_EN consumes inverted boxes without emitting any sample.
module bbox_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R14S,
    input  logic [COLORS-1:0][SIGFIG-1:0]             color_R14U,
    input  logic [1:0][1:0][SIGFIG-1:0]               box_R14S,
    input  logic                                      validTri_R14H,
    output logic                                      ready_R14H,
    input  logic [3:0]                                subSample_RnnnnU,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]             color_R16U,
    output logic [1:0][SIGFIG-1:0]                    sample_R16S,
    output logic                                      validSamp_R16H
);

    typedef enum logic [0:0] {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

    function automatic logic [SIGFIG-1:0] step_of(input logic [3:0] ss);
        logic [SIGFIG-1:0] one;
        one = {{(SIGFIG-1){1'b0}}, 1'b1} << RADIX;
        case (ss)
            4'b1000: step_of = one;
            4'b0100: step_of = one >> 1;
            4'b0010: step_of = one >> 2;
            4'b0001: step_of = one >> 3;
            default: step_of = one;
        endcase
    endfunction

    // One extra bit keeps x+step from wrapping near full-scale positive coordinates.
    function automatic logic signed [SIGFIG:0] sext(input logic [SIGFIG-1:0] v);
        sext = $signed({v[SIGFIG-1], v});
    endfunction

    state_t                                   state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]            color_q, color_d;
    logic [1:0][1:0][SIGFIG-1:0]              box_q, box_d;
    logic [1:0][SIGFIG-1:0]                   sample_q, sample_d;
    logic [SIGFIG-1:0]                        step_q, step_d;
    logic                                     valid_q, valid_d;

    logic signed [SIGFIG:0]                   nx_s, ny_s;
    logic                                     x_fits_s, y_fits_s, last_s;
    logic                                     ready_s, accept_s, load_s, skip_s;

    // Candidate next position and end-of-box detection
    always_comb begin
        nx_s     = sext(sample_q[0]) + sext(step_q);
        ny_s     = sext(sample_q[1]) + sext(step_q);
        x_fits_s = (nx_s <= sext(box_q[1][0]));
        y_fits_s = (ny_s <= sext(box_q[1][1]));
        last_s   = !x_fits_s && !y_fits_s;
    end

    // Handshake toward the bbox stage
    always_comb begin
        if (!rst) begin
            ready_s = 1'b0;
        end else if (state_q == ST_WAIT) begin
            ready_s = 1'b1;
        end else begin
            ready_s = last_s;
        end
        accept_s = ready_s && validTri_R14H;
`ifdef EMPTY_BOX_SKIP_EN
        skip_s = ($signed(box_R14S[0][0]) > $signed(box_R14S[1][0])) ||
                 ($signed(box_R14S[0][1]) > $signed(box_R14S[1][1]));
`else
        skip_s = 1'b0;
`endif
    end

    // Next-state and next-sample computation
    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        sample_d = sample_q;
        step_d   = step_q;
        valid_d  = valid_q;
        load_s   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_TEST: begin
                if (!last_s) begin
                    if (x_fits_s) begin
                        sample_d[0] = nx_s[SIGFIG-1:0];
                    end else begin
                        sample_d[0] = box_q[0][0];
                        sample_d[1] = ny_s[SIGFIG-1:0];
                    end
                end else if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
                valid_d = 1'b0;
            end
        endcase
        if (load_s) begin
            if (skip_s) begin
                state_d = ST_WAIT;
                valid_d = 1'b0;
            end else begin
                tri_d    = tri_R14S;
                color_d  = color_R14U;
                box_d    = box_R14S;
                sample_d = box_R14S[0];
                step_d   = step_of(subSample_RnnnnU);
                valid_d  = 1'b1;
                state_d  = ST_TEST;
            end
        end else begin
            step_d = step_q;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_WAIT;
            tri_q    <= '0;
            color_q  <= '0;
            box_q    <= '0;
            sample_q <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            sample_q <= sample_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
        end
    end

    // Output drive
    always_comb begin
        ready_R14H     = ready_s;
        tri_R16S       = tri_q;
        color_R16U     = color_q;
        sample_R16S    = sample_q;
        validSamp_R16H = valid_q;
    end

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Directed self-checking bench for bbox_sample_iter; honours EMPTY_BOX_SKIP_EN for the inverted-box case.
module tb_bbox_sample_iter;

    logic                         clk;
    logic                         rst;
    logic [2:0][2:0][23:0]        tri_in;
    logic [2:0][23:0]             color_in;
    logic [1:0][1:0][23:0]        box_in;
    logic                         valid_tri;
    logic                         ready;
    logic [3:0]                   sub_sample;
    logic [2:0][2:0][23:0]        tri_out;
    logic [2:0][23:0]             color_out;
    logic [1:0][23:0]             sample_out;
    logic                         valid_samp;

    int checks = 0;
    int errors = 0;

    bbox_sample_iter dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R14S         (tri_in),
        .color_R14U       (color_in),
        .box_R14S         (box_in),
        .validTri_R14H    (valid_tri),
        .ready_R14H       (ready),
        .subSample_RnnnnU (sub_sample),
        .tri_R16S         (tri_out),
        .color_R16U       (color_out),
        .sample_R16S      (sample_out),
        .validSamp_R16H   (valid_samp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] f24(input int v);
        logic [31:0] t;
        t = v;
        return t[23:0];
    endfunction

    function automatic logic [2:0][2:0][23:0] mk_tri(input int base);
        logic [2:0][2:0][23:0] t;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                t[v][a] = f24(base + 16 * v + a);
        return t;
    endfunction

    function automatic logic [2:0][23:0] mk_col(input int base);
        logic [2:0][23:0] c;
        for (int i = 0; i < 3; i++) c[i] = f24(base + i);
        return c;
    endfunction

    task automatic set_tri(input int base, input int llx, input int lly,
                           input int urx, input int ury, input logic [3:0] ss);
        tri_in       = mk_tri(base);
        color_in     = mk_col(base + 500);
        box_in[0][0] = f24(llx);
        box_in[0][1] = f24(lly);
        box_in[1][0] = f24(urx);
        box_in[1][1] = f24(ury);
        sub_sample   = ss;
        valid_tri    = 1'b1;
    endtask

    task automatic expect_samp(input string tag, input int x, input int y, input logic rdy);
        check_val({tag, "_valid"}, 256'(valid_samp), 256'(1'b1));
        check_val({tag, "_x"}, 256'(sample_out[0]), 256'(f24(x)));
        check_val({tag, "_y"}, 256'(sample_out[1]), 256'(f24(y)));
        check_val({tag, "_ready"}, 256'(ready), 256'(rdy));
    endtask

    int xs1 [6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ys1 [6] = '{0, 0, 0, 1024, 1024, 1024};

    initial begin
        rst        = 1'b0;
        valid_tri  = 1'b0;
        tri_in     = '0;
        color_in   = '0;
        box_in     = '0;
        sub_sample = 4'b1000;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid", 256'(valid_samp), 256'(1'b0));
        check_val("rst_ready", 256'(ready), 256'(1'b0));
        check_val("rst_sample", 256'(sample_out), 256'(0));
        rst = 1'b1;
        #1;
        check_val("idle_ready", 256'(ready), 256'(1'b1));

        // 1x, box (0,0)-(2048,1024): six samples
        set_tri(100, 0, 0, 2048, 1024, 4'b1000);
        @(negedge clk);
        valid_tri = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_samp($sformatf("t1_s%0d", i), xs1[i], ys1[i], (i == 5));
            @(negedge clk);
        end
        check_val("t1_tri", 256'(tri_out), 256'(mk_tri(100)));
        check_val("t1_col", 256'(color_out), 256'(mk_col(600)));
        check_val("t1_end_valid", 256'(valid_samp), 256'(1'b0));
        check_val("t1_end_ready", 256'(ready), 256'(1'b1));

        // 4x, box (0,0)-(1024,0)
        set_tri(200, 0, 0, 1024, 0, 4'b0100);
        @(negedge clk);
        valid_tri = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_samp($sformatf("t2_s%0d", i), 512 * i, 0, (i == 2));
            @(negedge clk);
        end
        check_val("t2_end_valid", 256'(valid_samp), 256'(1'b0));

        // back-to-back: B (two samples) then degenerate C at (-3072,5120)
        set_tri(300, 0, 0, 1024, 0, 4'b1000);
        @(negedge clk);
        expect_samp("t3_b0", 0, 0, 1'b0);
        check_val("t3_b0_tri", 256'(tri_out), 256'(mk_tri(300)));
        set_tri(400, -3072, 5120, -3072, 5120, 4'b1000);
        @(negedge clk);
        expect_samp("t3_b1", 1024, 0, 1'b1);
        check_val("t3_b1_tri", 256'(tri_out), 256'(mk_tri(300)));
        @(negedge clk);
        valid_tri = 1'b0;
        expect_samp("t3_c0", -3072, 5120, 1'b1);
        check_val("t3_c0_tri", 256'(tri_out), 256'(mk_tri(400)));
        check_val("t3_c0_col", 256'(color_out), 256'(mk_col(900)));
        @(negedge clk);
        check_val("t3_end_valid", 256'(valid_samp), 256'(1'b0));
        check_val("t3_end_ready", 256'(ready), 256'(1'b1));

        // reset during sample 3 of 6
        set_tri(500, 0, 0, 2048, 1024, 4'b1000);
        @(negedge clk);
        valid_tri = 1'b0;
        expect_samp("t4_s0", 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        expect_samp("t4_s2", 2048, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_val("t4_rst_valid", 256'(valid_samp), 256'(1'b0));
        check_val("t4_rst_sample", 256'(sample_out), 256'(0));
        check_val("t4_rst_tri", 256'(tri_out), 256'(0));
        check_val("t4_rst_col", 256'(color_out), 256'(0));
        check_val("t4_rst_ready", 256'(ready), 256'(1'b0));
        rst = 1'b1;
        #1;
        check_val("t4_rel_ready", 256'(ready), 256'(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("t4_idle%0d", i), 256'(valid_samp), 256'(1'b0));
        end

        // inverted box ll.x=2048, ur.x=0
        set_tri(600, 2048, 0, 0, 0, 4'b1000);
        @(negedge clk);
        valid_tri = 1'b0;
`ifdef EMPTY_BOX_SKIP_EN
        check_val("t5_skip_valid", 256'(valid_samp), 256'(1'b0));
        check_val("t5_skip_ready", 256'(ready), 256'(1'b1));
        @(negedge clk);
        check_val("t5_skip_valid2", 256'(valid_samp), 256'(1'b0));
`else
        expect_samp("t5_s0", 2048, 0, 1'b1);
        @(negedge clk);
        check_val("t5_end_valid", 256'(valid_samp), 256'(1'b0));
`endif

        // non-one-hot rate behaves as 1x
        set_tri(700, 0, 0, 1024, 0, 4'b0110);
        @(negedge clk);
        valid_tri = 1'b0;
        expect_samp("t6_s0", 0, 0, 1'b0);
        @(negedge clk);
        expect_samp("t6_s1", 1024, 0, 1'b1);
        @(negedge clk);
        check_val("t6_end_valid", 256'(valid_samp), 256'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
